// File: rtl/uart_tx_frame.sv
// uart_tx_frame: parametrised UART transmitter (start, DATA_BITS data LSB first,
// optional even/odd parity, 1 or 2 stop bits) with a ready/valid input.
// Optional feature macro UART_TX_HOLD_EN adds a one-word holding register so a
// second word can be queued while a frame is on the line.
//
// Handshake: a word transfers on a rising edge where i_Tx_DV && o_Tx_Ready;
// i_Tx_Byte is sampled on that same edge. i_Tx_DV while o_Tx_Ready=0 is dropped.
module uart_tx_frame #(
   parameter int CLKS_PER_BIT = 217,
   parameter int DATA_BITS    = 8,
   parameter int PARITY_MODE  = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                 i_Clock,
   input  logic                 i_Reset,
   input  logic                 i_Tx_DV,
   input  logic [DATA_BITS-1:0] i_Tx_Byte,
   output logic                 o_Tx_Ready,
   output logic                 o_Tx_Active,
   output logic                 o_Tx_Serial,
   output logic                 o_Tx_Done,
   output logic [2:0]           o_Dbg_State
);

   localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IDX_W = (DATA_BITS > 2) ? $clog2(DATA_BITS) : 1;

   // Reject illegal parameter combinations at elaboration.
   if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 ||
       PARITY_MODE < 0 || PARITY_MODE > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_params
      $error("uart_tx_frame: illegal parameter value");
   end

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } tx_state_t;

   tx_state_t            state_q, state_d;
   logic [CNT_W-1:0]     clk_cnt_q, clk_cnt_d;
   logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 parity_q, parity_d;
   logic                 serial_q, serial_d;
   logic                 done_q, done_d;

   logic                 clk_tc;
   logic                 last_data;
   logic                 last_stop;
   logic                 frame_end;
   logic                 ready;
   logic                 accept;
   logic                 start_frame;
   logic [DATA_BITS-1:0] new_word;

   // Bit-slot bookkeeping shared by every state.
   always_comb begin
      clk_tc    = (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1));
      last_data = (bit_idx_q == IDX_W'(DATA_BITS - 1));
      last_stop = (bit_idx_q == IDX_W'(STOP_BITS - 1));
      frame_end = (state_q == S_STOP) && clk_tc && last_stop;
   end

`ifdef UART_TX_HOLD_EN
   logic [DATA_BITS-1:0] hold_q;
   logic                 hold_full_q;
   logic                 start_direct;
   logic                 load_hold;
   logic                 take_hold;

   // Ready tracks the holding register; a new word goes straight to the line
   // when nothing is in flight (or the frame ends this edge), else it is held.
   always_comb begin
      ready        = ~hold_full_q;
      accept       = i_Tx_DV && ready;
      start_direct = accept && ((state_q == S_IDLE) || frame_end);
      load_hold    = accept && ~start_direct;
      take_hold    = frame_end && hold_full_q;
      start_frame  = start_direct || take_hold;
      new_word     = take_hold ? hold_q : i_Tx_Byte;
   end

   // Holding register: filled by a mid-frame accept, drained at frame end.
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         hold_q      <= '0;
         hold_full_q <= 1'b0;
      end else if (load_hold) begin
         hold_q      <= i_Tx_Byte;
         hold_full_q <= 1'b1;
      end else if (take_hold) begin
         hold_full_q <= 1'b0;
      end
   end
`else
   // Without a holding register the block only takes a word while idle.
   always_comb begin
      ready       = (state_q == S_IDLE);
      accept      = i_Tx_DV && ready;
      start_frame = accept;
      new_word    = i_Tx_Byte;
   end
`endif

   // Next-state, counters and next line value; the line is registered so it
   // changes only on clock edges.
   always_comb begin
      state_d   = state_q;
      clk_cnt_d = clk_cnt_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      parity_d  = parity_q;
      serial_d  = serial_q;
      done_d    = 1'b0;

      case (state_q)
         S_IDLE: begin
            serial_d  = 1'b1;
            clk_cnt_d = '0;
            bit_idx_d = '0;
         end
         S_START: begin
            if (clk_tc) begin
               state_d   = S_DATA;
               clk_cnt_d = '0;
               bit_idx_d = '0;
               serial_d  = shift_q[0];
            end else begin
               clk_cnt_d = clk_cnt_q + CNT_W'(1);
            end
         end
         S_DATA: begin
            if (clk_tc) begin
               clk_cnt_d = '0;
               if (last_data) begin
                  bit_idx_d = '0;
                  if (PARITY_MODE != 0) begin
                     state_d  = S_PARITY;
                     serial_d = parity_q;
                  end else begin
                     state_d  = S_STOP;
                     serial_d = 1'b1;
                  end
               end else begin
                  bit_idx_d = bit_idx_q + IDX_W'(1);
                  shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
                  serial_d  = shift_q[1];
               end
            end else begin
               clk_cnt_d = clk_cnt_q + CNT_W'(1);
            end
         end
         S_PARITY: begin
            if (clk_tc) begin
               state_d   = S_STOP;
               clk_cnt_d = '0;
               bit_idx_d = '0;
               serial_d  = 1'b1;
            end else begin
               clk_cnt_d = clk_cnt_q + CNT_W'(1);
            end
         end
         S_STOP: begin
            serial_d = 1'b1;
            if (clk_tc) begin
               clk_cnt_d = '0;
               if (last_stop) begin
                  state_d   = S_IDLE;
                  bit_idx_d = '0;
                  done_d    = 1'b1;
               end else begin
                  bit_idx_d = bit_idx_q + IDX_W'(1);
               end
            end else begin
               clk_cnt_d = clk_cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d   = S_IDLE;
            clk_cnt_d = '0;
            bit_idx_d = '0;
            serial_d  = 1'b1;
         end
      endcase

      // A new word overrides the idle/return path and begins its start bit.
      if (start_frame) begin
         state_d   = S_START;
         clk_cnt_d = '0;
         bit_idx_d = '0;
         shift_d   = new_word;
         parity_d  = (PARITY_MODE == 2) ? ~(^new_word) : (^new_word);
         serial_d  = 1'b0;
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         state_q   <= S_IDLE;
         clk_cnt_q <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         parity_q  <= 1'b0;
         serial_q  <= 1'b1;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         clk_cnt_q <= clk_cnt_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         parity_q  <= parity_d;
         serial_q  <= serial_d;
         done_q    <= done_d;
      end
   end

   // Output mapping.
   always_comb begin
      o_Tx_Ready  = ready;
      o_Tx_Active = (state_q != S_IDLE);
      o_Tx_Serial = serial_q;
      o_Tx_Done   = done_q;
      o_Dbg_State = state_q;
   end

endmodule
